// File: rtl/seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scanner
//  Brief    : Four-digit multiplexed seven-segment scanner with per-digit
//             blanking, leading-zero suppression and whole-display blink.
//             Segment and anode outputs are active-low and registered.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scanner #(
   parameter int unsigned PRESCALE     = 100000,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [3:0]  blank,
   input  logic        lz_blank,
   input  logic        blink_en,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam logic [19:0] c_presc_last = 20'(PRESCALE - 1);
   localparam logic [7:0]  c_blink_last = 8'(BLINK_FRAMES - 1);
   localparam logic [6:0]  c_seg_off    = 7'b1111111;
   localparam logic [3:0]  c_an_off     = 4'b1111;

   logic [19:0] presc_q, presc_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        phase_q, phase_d;
   logic [15:0] value_sh_q, value_sh_d;
   logic [3:0]  blank_sh_q, blank_sh_d;
   logic        lz_sh_q, lz_sh_d;
   logic        frame_done_q, frame_done_d;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  an_q, an_d;

   logic        w_tick;
   logic        w_wrap;
   logic        w_lz;
   logic        w_off;
   logic [3:0]  w_nibble;

   // Hex nibble to active-low segment pattern, bit 6 = g .. bit 0 = a.
   function automatic logic [6:0] f_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Timebase, digit index, frame/blink counters and shadow capture.
   always_comb begin
      w_tick       = (presc_q == c_presc_last);
      w_wrap       = w_tick && (idx_q == 2'd3);
      presc_d      = w_tick ? 20'd0 : presc_q + 20'd1;
      idx_d        = w_tick ? idx_q + 2'd1 : idx_q;
      frame_done_d = w_wrap;
      frame_cnt_d  = frame_cnt_q;
      phase_d      = phase_q;
      value_sh_d   = value_sh_q;
      blank_sh_d   = blank_sh_q;
      lz_sh_d      = lz_sh_q;
      if (w_wrap) begin
         // Shadow only reloads at the frame boundary so a frame is coherent.
         value_sh_d = value;
         blank_sh_d = blank;
         lz_sh_d    = lz_blank;
         if (frame_cnt_q == c_blink_last) begin
            frame_cnt_d = 8'd0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end
   end

   // Digit selection, blanking decision and segment decode for the next output.
   always_comb begin
      w_nibble = value_sh_q[{idx_q, 2'b00} +: 4];
      w_lz     = 1'b0;
      case (idx_q)
         2'd1:    w_lz = lz_sh_q && (value_sh_q[15:4]  == 12'd0);
         2'd2:    w_lz = lz_sh_q && (value_sh_q[15:8]  == 8'd0);
         2'd3:    w_lz = lz_sh_q && (value_sh_q[15:12] == 4'd0);
         default: w_lz = 1'b0;  // digit 0 always shows, so zero reads "0"
      endcase
      // blink_en is taken live so disabling blink takes effect at once.
      w_off = blank_sh_q[idx_q] | w_lz | (phase_q & blink_en);
      seg_d = w_off ? c_seg_off : f_decode(w_nibble);
      an_d  = w_off ? c_an_off  : ~(4'b0001 << idx_q);
   end

   // State register; reset keeps the shadow tracking the inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q      <= 20'd0;
         idx_q        <= 2'd0;
         frame_cnt_q  <= 8'd0;
         phase_q      <= 1'b0;
         frame_done_q <= 1'b0;
         seg_q        <= c_seg_off;
         an_q         <= c_an_off;
         value_sh_q   <= value;
         blank_sh_q   <= blank;
         lz_sh_q      <= lz_blank;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         frame_cnt_q  <= frame_cnt_d;
         phase_q      <= phase_d;
         frame_done_q <= frame_done_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         value_sh_q   <= value_sh_d;
         blank_sh_q   <= blank_sh_d;
         lz_sh_q      <= lz_sh_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scanner
//  Brief    : Self-checking bench for seg_scanner (PRESCALE=4, BLINK_FRAMES=2).
//             A reference model derived from the cycle count since reset
//             pushes the expected {frame_done, an, seg} at each clock edge;
//             the sample taken after the edge pops and compares it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scanner;

   localparam int P  = 4;
   localparam int BF = 2;
   localparam int FRAME = 4 * P;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  blank;
   logic        lz_blank;
   logic        blink_en;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   int          k = 0;           // edges since the last reset edge
   logic [15:0] sh_v;
   logic [3:0]  sh_b;
   logic        sh_lz;
   logic [11:0] sb[$];

   seg_scanner #(.PRESCALE(P), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .blank      (blank),
      .lz_blank   (lz_blank),
      .blink_en   (blink_en),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got fd=%b an=%b seg=%b, want fd=%b an=%b seg=%b",
                  tag, obs[11], obs[10:7], obs[6:0], exp[11], exp[10:7], exp[6:0]);
      end
   endtask

   function automatic logic [6:0] dec(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[n];
   endfunction

   // Expected outputs after the current edge, from inputs seen at that edge.
   task automatic model_edge();
      int          d, f, ph;
      logic        off, fd;
      logic [15:0] hi;
      if (rst) begin
         k     = 0;
         sh_v  = value;
         sh_b  = blank;
         sh_lz = lz_blank;
         sb.push_back({1'b0, 4'b1111, 7'b1111111});
      end else begin
         k++;
         d   = ((k - 1) / P) % 4;
         f   = (k - 1) / FRAME;
         ph  = (f / BF) % 2;
         hi  = sh_v >> (4 * d);
         off = sh_b[d] || (sh_lz && d > 0 && hi == 16'd0) || (ph == 1 && blink_en);
         fd  = (k % FRAME) == 0;
         if (off) sb.push_back({fd, 4'b1111, 7'b1111111});
         else     sb.push_back({fd, ~(4'b0001 << d), dec(hi[3:0])});
         if (fd) begin
            sh_v  = value;
            sh_b  = blank;
            sh_lz = lz_blank;
         end
      end
   endtask

   task automatic step(input string tag);
      logic [11:0] e;
      @(posedge clk);
      model_edge();
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk($sformatf("%s k=%0d", tag, k), {frame_done, an, seg}, e);
      end
      @(negedge clk);
   endtask

   function automatic int cur_digit();
      return (k / P) % 4;
   endfunction

   function automatic int cur_phase();
      return ((k / FRAME) / BF) % 2;
   endfunction

   initial begin
      rst = 1'b1; value = 16'h12AF; blank = 4'b0000; lz_blank = 1'b0; blink_en = 1'b0;
      repeat (3) step("reset");
      rst = 1'b0;
      repeat (20) step("scan_12af");
      value = 16'h0000;                        // mid-frame change
      repeat (30) step("midframe_change");

      value = 16'h0007; lz_blank = 1'b1;
      repeat (40) step("lz_0007");
      value = 16'h0000;
      repeat (36) step("lz_zero");

      lz_blank = 1'b0; blank = 4'b0100; value = 16'h8888;
      repeat (40) step("blank_d2");
      blank = 4'b0000;

      value = 16'h3456; repeat (34) step("dec_3456");
      value = 16'h9BCD; repeat (34) step("dec_9bcd");
      value = 16'hE0F1; repeat (34) step("dec_e0f1");

      blink_en = 1'b1;
      repeat (70) step("blink");
      for (int i = 0; i < 80 && !(cur_phase() == 1 && (k % P) == 1); i++) step("blink_seek");
      blink_en = 1'b0;                         // release while blanked
      repeat (12) step("blink_release");

      for (int i = 0; i < 40 && !(cur_digit() == 2 && (k % P) == 1); i++) step("seek_d2");
      rst = 1'b1;
      step("midrst");
      rst = 1'b0;
      repeat (40) step("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
